lcd_refresh_sched: RTL and testbench

Scheduler and port arbiter for the 128x64 dual-controller LCD path. It generates periodic refresh-start pulses for the LCD driver, which acts on a start falling edge. It owns the single-port 1024x8 frame-buffer RAM and shares it between the game renderer (writes) and the LCD driver (reads, addressed by the driver's {x[3:0], y[5:0]} address). Renderer writes are locked out for the duration of a refresh, and a frame that would tear is deferred.

---
 rtl/lcd_refresh_sched_pkg.sv | 17 +
 rtl/lcd_refresh_sched_tick_gen.sv | 31 +++
 rtl/lcd_refresh_sched.sv | 139 +++++++++++++
 tb/tb_lcd_refresh_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_refresh_sched_pkg.sv
// Shared types and geometry constants for the LCD refresh scheduler.
package lcd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    START   = 2'd2,
    REFRESH = 2'd3
  } state_e;

  // 128x64 panel split across two controllers, 8 pages of 64 columns each.
  localparam int LCD_PAGES = 8;
  localparam int LCD_COLS  = 64;
  localparam int LCD_CHIPS = 2;
  localparam int FB_DEPTH  = 1024;

endpackage

// File: rtl/lcd_refresh_sched_tick_gen.sv
// Free-running 0..PERIOD-1 counter with a registered one-cycle pulse on wrap.
module lcd_tick_gen #(
  parameter int PERIOD = 833333
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;
  logic          tick_q;

  assign wrap  = (cnt_q == CW'(PERIOD - 1));
  assign cnt_d = wrap ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= wrap;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/lcd_refresh_sched.sv
// Refresh scheduler and frame-buffer port arbiter between renderer writes and LCD driver reads.
//   state   | meaning
//   IDLE    | renderer owns RAM, waiting for frame tick
//   WAIT    | tick arrived while renderer busy, refresh deferred
//   START   | start_o held high for START_HI clocks
//   REFRESH | driver owns RAM for REFRESH_CYCLES clocks
module lcd_refresh_sched
  import lcd_sched_pkg::*;
#(
  parameter int FRAME_CYCLES   = 833333,
  parameter int START_HI       = 2,
  parameter int REFRESH_CYCLES = 40000,
  parameter int ADDR_W         = $clog2(FB_DEPTH),
  parameter int DATA_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              render_busy_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_gnt_o,
  input  logic [ADDR_W-1:0] drv_addr_i,
  output logic [DATA_W-1:0] drv_data_o,
  output logic              start_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              refreshing_o,
  output logic              frame_late_o,
  output logic [7:0]        frame_cnt_o
);

  localparam int PH_MAX = (REFRESH_CYCLES > START_HI) ? REFRESH_CYCLES : START_HI;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              late_q, late_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              start_q;
  logic              rd_prev_q;
  logic [DATA_W-1:0] drv_data_q;
  logic              tick;
  logic              gnt;

  lcd_tick_gen #(.PERIOD(FRAME_CYCLES)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  // Phase counter counts down to a terminal count of zero in START and REFRESH.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    late_d  = late_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          if (render_busy_i) begin
            state_d = WAIT;
            late_d  = 1'b1;
          end else begin
            state_d = START;
            phase_d = PH_W'(START_HI - 1);
          end
        end
      end
      WAIT: begin
        if (!render_busy_i) begin
          state_d = START;
          phase_d = PH_W'(START_HI - 1);
        end
      end
      START: begin
        if (phase_q == '0) begin
          state_d = REFRESH;
          phase_d = PH_W'(REFRESH_CYCLES - 1);
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      REFRESH: begin
        if (phase_q == '0) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      late_q     <= 1'b0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      rd_prev_q  <= 1'b0;
      drv_data_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      late_q    <= late_d;
      cnt_q     <= cnt_d;
      start_q   <= (state_d == START);
      rd_prev_q <= !mem_we_o;
      if (rd_prev_q) drv_data_q <= mem_rdata_i;
    end
  end

  // Port outputs are forced quiet while reset is asserted.
  always_comb begin
    gnt         = wr_req_i && (state_q != REFRESH) && !rst;
    mem_we_o    = gnt;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt) begin
      mem_addr_o  = wr_addr_i;
      mem_wdata_o = wr_data_i;
    end else if (!rst) begin
      mem_addr_o  = drv_addr_i;
    end
  end

  assign wr_gnt_o     = gnt;
  assign drv_data_o   = drv_data_q;
  assign start_o      = start_q;
  assign refreshing_o = (state_q == REFRESH);
  assign frame_late_o = late_q;
  assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_lcd_refresh_sched.sv
// Directed bench for lcd_refresh_sched with a behavioural RAM, a refresh-window model and a read scoreboard.
module tb_lcd_refresh_sched;

  localparam int FRAME = 100;
  localparam int SHI   = 2;
  localparam int RCY   = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       render_busy_i;
  logic       wr_req_i;
  logic [9:0] wr_addr_i;
  logic [7:0] wr_data_i;
  logic       wr_gnt_o;
  logic [9:0] drv_addr_i;
  logic [7:0] drv_data_o;
  logic       start_o;
  logic [9:0] mem_addr_o;
  logic       mem_we_o;
  logic [7:0] mem_wdata_o;
  logic [7:0] mem_rdata_i;
  logic       refreshing_o;
  logic       frame_late_o;
  logic [7:0] frame_cnt_o;

  lcd_refresh_sched #(
    .FRAME_CYCLES   (FRAME),
    .START_HI       (SHI),
    .REFRESH_CYCLES (RCY),
    .ADDR_W         (10),
    .DATA_W         (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .render_busy_i (render_busy_i),
    .wr_req_i      (wr_req_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .wr_gnt_o      (wr_gnt_o),
    .drv_addr_i    (drv_addr_i),
    .drv_data_o    (drv_data_o),
    .start_o       (start_o),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .refreshing_o  (refreshing_o),
    .frame_late_o  (frame_late_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  always #5 clk = ~clk;

  logic [7:0] ram     [0:1023] = '{default: 8'h00};
  logic [7:0] exp_ram [0:1023] = '{default: 8'h00};

  always @(posedge clk) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= ram[mem_addr_o];
  end

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int         total = 0;
  int         bad   = 0;
  int         starts[$];
  int         late_from;
  logic [7:0] sb[$];
  logic [9:0] rd_addrs [12] = '{10'h2C5, 10'h001, 10'h3FF, 10'h080, 10'h155, 10'h2AA,
                                10'h0C5, 10'h3C5, 10'h123, 10'h200, 10'h07E, 10'h301};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each entry of starts[] is the first cycle start_o is high for one refresh.
  function automatic bit m_start(int c);
    foreach (starts[i]) if (c >= starts[i] && c < starts[i] + SHI) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ref(int c);
    foreach (starts[i]) if (c >= starts[i] + SHI && c < starts[i] + SHI + RCY) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_cnt(int c);
    int n = 0;
    foreach (starts[i]) if (c >= starts[i] + SHI + RCY) n++;
    return n;
  endfunction

  task automatic check_cycle(input int c);
    chk("start", 32'(start_o), 32'(m_start(c)));
    chk("refreshing", 32'(refreshing_o), 32'(m_ref(c)));
    chk("frame_cnt", 32'(frame_cnt_o), 32'(m_cnt(c) % 256));
    chk("frame_late", 32'(frame_late_o), 32'(c >= late_from));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_start"}, 32'(start_o), 0);
    chk({tag, "_refreshing"}, 32'(refreshing_o), 0);
    chk({tag, "_late"}, 32'(frame_late_o), 0);
    chk({tag, "_cnt"}, 32'(frame_cnt_o), 0);
    chk({tag, "_gnt"}, 32'(wr_gnt_o), 0);
    chk({tag, "_we"}, 32'(mem_we_o), 0);
    chk({tag, "_addr"}, 32'(mem_addr_o), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata_o), 0);
    chk({tag, "_drv_data"}, 32'(drv_data_o), 0);
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         c;
    logic       exp_g;
    logic [9:0] wa;
    logic [7:0] exp_d;

    rst           = 1'b1;
    render_busy_i = 1'b0;
    wr_req_i      = 1'b1;
    wr_addr_i     = 10'h3A5;
    wr_data_i     = 8'hA5;
    drv_addr_i    = 10'h155;
    starts        = {101, 201, 316, 516, 601};
    late_from     = 301;
    wa            = '0;

    repeat (3) @(negedge clk);
    check_reset("reset");
    wr_req_i = 1'b0;
    rst      = 1'b0;

    while (1) begin
      @(negedge clk);
      c = cyc;
      check_cycle(c);

      wr_req_i = 1'b0;
      if (c >= 90 && c < 130) begin
        wr_req_i  = 1'b1;
        wr_addr_i = wa;
        wr_data_i = wa[7:0] ^ 8'h5A;
        wa++;
      end
      if (c >= 150 && c < 162) begin
        wr_req_i  = 1'b1;
        wr_addr_i = rd_addrs[c-150];
        wr_data_i = rd_addrs[c-150][7:0];
      end
      if (c == 290) render_busy_i = 1'b1;
      if (c == 315) render_busy_i = 1'b0;
      if (c == 390) render_busy_i = 1'b1;
      if (c == 515) render_busy_i = 1'b0;

      if (sb.size() == 2 || (c > 215 && sb.size() > 0)) begin
        exp_d = sb.pop_front();
        chk("drv_data", 32'(drv_data_o), 32'(exp_d));
      end
      if (c >= 204 && c < 216) begin
        drv_addr_i = rd_addrs[c-204];
        sb.push_back(rd_addrs[c-204][7:0]);
      end

      #1;
      if (wr_req_i) begin
        exp_g = !m_ref(c);
        chk("wr_gnt", 32'(wr_gnt_o), 32'(exp_g));
        chk("mem_we", 32'(mem_we_o), 32'(exp_g));
        if (exp_g) begin
          chk("mem_addr", 32'(mem_addr_o), 32'(wr_addr_i));
          chk("mem_wdata", 32'(mem_wdata_o), 32'(wr_data_i));
          exp_ram[wr_addr_i] = wr_data_i;
        end
      end else begin
        chk("mem_we_idle", 32'(mem_we_o), 0);
      end

      if (c == 140)
        for (int a = 0; a < 64; a++) chk($sformatf("ram[%0d]", a), 32'(ram[a]), 32'(exp_ram[a]));

      if (c == 609) break;
    end

    // Abort on the seventh REFRESH cycle with a pending write.
    chk("pre_abort_refreshing", 32'(refreshing_o), 1);
    wr_req_i  = 1'b1;
    wr_addr_i = 10'h3A5;
    #2 rst = 1'b1;
    #1 check_reset("abort");
    repeat (2) @(negedge clk);
    wr_req_i  = 1'b0;
    rst       = 1'b0;
    starts    = {101};
    late_from = 1 << 30;

    while (cyc < 130) begin
      @(negedge clk);
      check_cycle(cyc);
    end

    while (cyc < 100 * 256 + SHI + RCY) @(negedge clk);
    chk("frame_cnt_255", 32'(frame_cnt_o), 255);
    @(negedge clk);
    chk("frame_cnt_wrap", 32'(frame_cnt_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
